// File: rtl/cellrv32_package.sv
// Shared VMU definitions: line/bus geometry, memory request and response
// records, vector memory opcodes and the responder FSM state type.
package cellrv32_package;

  localparam int REQ_DATA_WIDTH   = 256;
  localparam int ADDR_WIDTH       = 32;
  localparam int BUS_WIDTH        = 32;
  localparam int VECTOR_LANES     = 8;
  localparam int TICKET_WIDTH     = $clog2(VECTOR_LANES) + 1;
  localparam int MICROOP_WIDTH    = 7;
  localparam int BEATS            = REQ_DATA_WIDTH / BUS_WIDTH;
  localparam int LINE_OFFSET_BITS = $clog2(REQ_DATA_WIDTH / 8);
  localparam int BEAT_SHIFT       = $clog2(BUS_WIDTH / 8);

  localparam logic [MICROOP_WIDTH-1:0] opcode_vload_c  = 7'b0000111;
  localparam logic [MICROOP_WIDTH-1:0] opcode_vstore_c = 7'b0100111;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     address;
    logic [MICROOP_WIDTH-1:0]  microop;
    logic [TICKET_WIDTH-1:0]   ticket;
    logic [REQ_DATA_WIDTH-1:0] data;
  } vector_mem_req;

  typedef struct packed {
    logic [TICKET_WIDTH-1:0]   ticket;
    logic [REQ_DATA_WIDTH-1:0] data;
  } vector_mem_resp;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} vmu_resp_state_t;

  // Align a byte address down to the start of its line.
  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask = mask << LINE_OFFSET_BITS;
    return addr & mask;
  endfunction

endpackage

// File: rtl/vmu_mem_responder_if.sv
// Request/response and memory-bus signal bundle of the VMU memory responder.
// The slave modport is the responder's view, master is the VMU/bus side.
interface vmu_mem_responder_if;
  import cellrv32_package::*;

  logic                  req_valid_i;
  vector_mem_req         req_i;
  logic                  req_ready_o;
  logic                  resp_valid_o;
  vector_mem_resp        resp_o;
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [BUS_WIDTH-1:0]  bus_wdata_o;
  logic                  bus_ack_i;
  logic [BUS_WIDTH-1:0]  bus_rdata_i;
  logic                  idle_o;

  modport slave (
    input  req_valid_i, req_i, bus_ack_i, bus_rdata_i,
    output req_ready_o, resp_valid_o, resp_o, bus_req_o, bus_we_o,
           bus_addr_o, bus_wdata_o, idle_o
  );

  modport master (
    output req_valid_i, req_i, bus_ack_i, bus_rdata_i,
    input  req_ready_o, resp_valid_o, resp_o, bus_req_o, bus_we_o,
           bus_addr_o, bus_wdata_o, idle_o
  );

endinterface

// File: rtl/vmu_beat_packer.sv
// Beat counter, read-line assembly slots and write-slice select for
// splitting one line into BEATS bus words (beat 0 = least-significant word).
module vmu_beat_packer #(
  parameter int BEATS     = 8,
  parameter int BUS_WIDTH = 32,
  localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       beat_ack,
  input  logic                       capture,
  input  logic [BUS_WIDTH-1:0]       rdata,
  input  logic [BEATS*BUS_WIDTH-1:0] wline,
  output logic [CNT_WIDTH-1:0]       cnt,
  output logic                       last_beat,
  output logic [BEATS*BUS_WIDTH-1:0] rline,
  output logic [BUS_WIDTH-1:0]       wdata
);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [BUS_WIDTH-1:0] wslice [BEATS];

  assign last_beat = (cnt_reg == CNT_WIDTH'(BEATS - 1));
  assign cnt       = cnt_reg;

  // Beat counter: advances on each accepted beat and wraps after the last one.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (beat_ack) begin
      cnt_reg <= last_beat ? '0 : cnt_reg + CNT_WIDTH'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      logic [BUS_WIDTH-1:0] slot_reg;

      // Assembly slot gi captures read data when its own beat is acknowledged.
      always_ff @(posedge clk) begin
        if (srst) begin
          slot_reg <= '0;
        end else if (capture && beat_ack && (cnt_reg == CNT_WIDTH'(gi))) begin
          slot_reg <= rdata;
        end
      end

      assign rline[gi*BUS_WIDTH +: BUS_WIDTH] = slot_reg;
      assign wslice[gi] = wline[gi*BUS_WIDTH +: BUS_WIDTH];
    end
  endgenerate

  // Write data follows the registered counter, so it stays put during waits.
  assign wdata = wslice[cnt_reg];

endmodule

// File: rtl/vmu_mem_responder.sv
// Memory-side responder for the VMU cache port: accepts one line request,
// moves it as single-outstanding 32-bit bus beats and returns load data
// as a one-cycle response tagged with the request ticket.
module vmu_mem_responder
  import cellrv32_package::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  vmu_mem_responder_if.slave  io
);

  localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

  vmu_resp_state_t           state_reg, state_next;
  logic                      ready_reg;
  logic [ADDR_WIDTH-1:0]     base_reg;
  logic [TICKET_WIDTH-1:0]   ticket_reg;
  logic [REQ_DATA_WIDTH-1:0] data_reg;

  logic                      handshake;
  logic                      bus_req;
  logic                      bus_we;
  logic                      resp_valid;
  logic                      idle;
  logic                      beat_ack;
  logic                      last_beat;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [REQ_DATA_WIDTH-1:0] rline;
  logic [BUS_WIDTH-1:0]      wdata;

  assign handshake = io.req_valid_i & ready_reg;
  // Acks that arrive with no beat outstanding are ignored.
  assign beat_ack  = io.bus_ack_i & bus_req;

  // State register; ready is a registered decode of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == IDLE);
    end
  end

  // Request capture: line base, ticket and store data on every handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_reg   <= '0;
      ticket_reg <= '0;
      data_reg   <= '0;
    end else if (handshake) begin
      base_reg   <= line_base(io.req_i.address);
      ticket_reg <= io.req_i.ticket;
      data_reg   <= io.req_i.data;
    end
  end

  // Next-state logic; unknown microops are accepted and dropped in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (io.req_i.microop == opcode_vload_c) begin
            state_next = RD;
          end else if (io.req_i.microop == opcode_vstore_c) begin
            state_next = WR;
          end
        end
      end
      RD:      if (beat_ack && last_beat) state_next = RESP;
      WR:      if (beat_ack && last_beat) state_next = IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    resp_valid = 1'b0;
    idle       = 1'b0;
    case (state_reg)
      IDLE:    idle = 1'b1;
      RD:      bus_req = 1'b1;
      WR: begin
        bus_req = 1'b1;
        bus_we  = 1'b1;
      end
      RESP:    resp_valid = 1'b1;
      default: idle = 1'b0;
    endcase
  end

  vmu_beat_packer #(
    .BEATS     (BEATS),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_packer (
    .clk       (clk_i),
    .srst      (rst_i),
    .beat_ack  (beat_ack),
    .capture   (state_reg == RD),
    .rdata     (io.bus_rdata_i),
    .wline     (data_reg),
    .cnt       (cnt),
    .last_beat (last_beat),
    .rline     (rline),
    .wdata     (wdata)
  );

  assign io.req_ready_o  = ready_reg;
  assign io.resp_valid_o = resp_valid;
  assign io.resp_o       = {ticket_reg, rline};
  assign io.bus_req_o    = bus_req;
  assign io.bus_we_o     = bus_we;
  assign io.bus_addr_o   = base_reg + (ADDR_WIDTH'(cnt) << BEAT_SHIFT);
  assign io.bus_wdata_o  = wdata;
  assign io.idle_o       = idle;

endmodule

// File: tb/tb_vmu_mem_responder.sv
// Bench for vmu_mem_responder: a word-addressed memory model behind a bus
// slave with programmable wait states, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_vmu_mem_responder;
  import cellrv32_package::*;

  localparam logic [6:0] OP_OTHER = 7'b0110011;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  vmu_mem_responder_if io();

  vmu_mem_responder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .io    (io)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference memory: explicitly written words, deterministic pattern elsewhere.
  logic [31:0] mem [int unsigned];
  int  wait_cycles = 0;
  bit  spurious_en = 1'b1;

  logic [31:0] log_addr  [$];
  bit          log_we    [$];
  logic [31:0] log_wdata [$];
  int          resp_cyc  [$];
  logic [3:0]  resp_tkt  [$];
  logic [255:0] resp_dat [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus slave: acks each beat after wait_cycles wait states, checks hold-stable.
  initial begin
    int wc;
    bit in_beat;
    bit h_we;
    logic [31:0] h_addr, h_wdata;
    io.bus_ack_i   = 1'b0;
    io.bus_rdata_i = '0;
    in_beat = 1'b0;
    wc = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1) begin
        io.bus_ack_i = 1'b0;
        in_beat = 1'b0;
      end else if (io.bus_req_o === 1'b1) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          wc = 0;
          h_addr  = io.bus_addr_o;
          h_we    = io.bus_we_o;
          h_wdata = io.bus_wdata_o;
        end else begin
          check_val("hold_addr", io.bus_addr_o, h_addr);
          check_val("hold_we", io.bus_we_o, h_we);
          if (h_we) check_val("hold_wdata", io.bus_wdata_o, h_wdata);
        end
        if (wc >= wait_cycles) begin
          io.bus_ack_i = 1'b1;
          in_beat = 1'b0;
          log_addr.push_back(h_addr);
          log_we.push_back(h_we);
          log_wdata.push_back(h_wdata);
          if (h_we) begin
            mem[h_addr] = h_wdata;
            io.bus_rdata_i = $urandom;
          end else begin
            io.bus_rdata_i = mem_rd(h_addr);
          end
        end else begin
          io.bus_ack_i = 1'b0;
          io.bus_rdata_i = $urandom;
          wc++;
        end
      end else begin
        in_beat = 1'b0;
        io.bus_ack_i = spurious_en && ($urandom_range(0, 3) == 0);
        io.bus_rdata_i = $urandom;
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk_i);
      if (io.resp_valid_o === 1'b1) begin
        resp_cyc.push_back(cyc);
        resp_tkt.push_back(io.resp_o.ticket);
        resp_dat.push_back(io.resp_o.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present a request from a negedge until accepted; t = handshake cycle.
  // Returns at the negedge after the handshake with valid still asserted.
  task automatic send(input vector_mem_req r, output int t);
    t = -1;
    io.req_i = r;
    io.req_valid_i = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (io.req_ready_o === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk_i);
    end
    if (t < 0) check_val("handshake_timeout", 0, 1);
    else @(negedge clk_i);
  endtask

  task automatic wait_ready(output int t);
    t = -1;
    for (int k = 0; k < 400; k++) begin
      if (io.req_ready_o === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk_i);
    end
    if (t < 0) check_val("ready_timeout", 0, 1);
  endtask

  function automatic vector_mem_req mk_req(input logic [31:0] addr, input logic [6:0] op,
                                           input logic [3:0] tkt, input logic [255:0] line);
    vector_mem_req r;
    r.address = addr;
    r.microop = op;
    r.ticket  = tkt;
    r.data    = line;
    return r;
  endfunction

  // One complete transaction checked against the memory model and timing rules.
  task automatic run_txn(input logic [31:0] addr, input logic [6:0] op, input logic [3:0] tkt,
                         input logic [255:0] line, input int waits);
    int t, tr, exp_ready, exp_beats;
    bit is_ld, is_st;
    logic [31:0] base;
    logic [255:0] exp_line;
    base  = addr & 32'hFFFF_FFE0;
    is_ld = (op == opcode_vload_c);
    is_st = (op == opcode_vstore_c);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = mem_rd(base + 32'(4*i));
    wait_cycles = waits;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    resp_cyc.delete(); resp_tkt.delete(); resp_dat.delete();
    send(mk_req(addr, op, tkt, line), t);
    io.req_valid_i = 1'b0;
    if (t < 0) return;
    wait_ready(tr);
    exp_ready = is_ld ? t + 2 + 8*(1+waits) : (is_st ? t + 1 + 8*(1+waits) : t + 1);
    check_val("ready_cycle", tr, exp_ready);
    check_val("idle_when_ready", io.idle_o, 1);
    repeat (2) @(negedge clk_i);
    check_val("resp_count", resp_cyc.size(), is_ld ? 1 : 0);
    if (is_ld && resp_cyc.size() > 0) begin
      check_val("resp_cycle", resp_cyc[0], t + 1 + 8*(1+waits));
      check_val("resp_ticket", resp_tkt[0], tkt);
      check_val("resp_data", resp_dat[0], exp_line);
    end
    exp_beats = (is_ld || is_st) ? 8 : 0;
    check_val("beat_count", log_addr.size(), exp_beats);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      check_val("beat_addr", log_addr[i], base + 32'(4*i));
      check_val("beat_we", log_we[i], is_st);
      if (is_st) begin
        check_val("beat_wdata", log_wdata[i], line[32*i +: 32]);
        check_val("mem_after_store", mem_rd(base + 32'(4*i)), line[32*i +: 32]);
      end
    end
    $display("txn op=%02h addr=%08h tkt=%0d waits=%0d accepted@%0d ready@%0d resps=%0d beats=%0d",
             op, addr, tkt, waits, t, tr, resp_cyc.size(), log_addr.size());
  endtask

  initial begin
    int t1, t2, tr;
    logic [255:0] line;
    logic [6:0] op;

    rst_i = 1'b1;
    io.req_valid_i = 1'b0;
    io.req_i = '0;
    repeat (3) @(negedge clk_i);
    check_val("rst_ready", io.req_ready_o, 0);
    check_val("rst_idle", io.idle_o, 1);
    check_val("rst_bus_req", io.bus_req_o, 0);
    check_val("rst_bus_we", io.bus_we_o, 0);
    check_val("rst_resp_valid", io.resp_valid_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("post_rst_ready", io.req_ready_o, 1);
    check_val("post_rst_addr", io.bus_addr_o, 0);

    // Load at an unaligned address, immediate ack, known memory words.
    for (int i = 0; i < 8; i++) mem[32'h1000_0000 + 32'(4*i)] = 32'h100 + 32'(i);
    run_txn(32'h1000_0004, opcode_vload_c, 4'd5, '0, 0);

    // Store {7..0}, then read it back with two wait states per beat.
    for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'(i);
    run_txn(32'h2000_0020, opcode_vstore_c, 4'd2, line, 0);
    run_txn(32'h2000_0020, opcode_vload_c, 4'd9, '0, 2);

    // Back-to-back: store, then a load held valid until ready returns.
    for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
    wait_cycles = 0;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    resp_cyc.delete(); resp_tkt.delete(); resp_dat.delete();
    send(mk_req(32'h3000_0040, opcode_vstore_c, 4'd1, line), t1);
    send(mk_req(32'h3000_0044, opcode_vload_c, 4'd12, '0), t2);
    io.req_valid_i = 1'b0;
    check_val("b2b_accept_cycle", t2, t1 + 9);
    wait_ready(tr);
    repeat (3) @(negedge clk_i);
    check_val("b2b_resp_count", resp_cyc.size(), 1);
    if (resp_cyc.size() > 0) begin
      check_val("b2b_resp_ticket", resp_tkt[0], 4'd12);
      check_val("b2b_resp_data", resp_dat[0], line);
    end
    check_val("b2b_beats", log_addr.size(), 16);
    $display("txn b2b store@%0d load@%0d resps=%0d", t1, t2, resp_cyc.size());

    // Reset asserted while beat 3 of a load is on the bus.
    resp_cyc.delete(); resp_tkt.delete(); resp_dat.delete();
    send(mk_req(32'h1000_0000, opcode_vload_c, 4'd3, '0), t1);
    io.req_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("midrst_busy", io.bus_req_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_val("midrst_bus_req", io.bus_req_o, 0);
    check_val("midrst_idle", io.idle_o, 1);
    check_val("midrst_ready_low", io.req_ready_o, 0);
    rst_i = 1'b0;
    repeat (12) @(negedge clk_i);
    check_val("midrst_no_resp", resp_cyc.size(), 0);
    check_val("midrst_ready", io.req_ready_o, 1);
    $display("txn reset during beat 3 of load accepted@%0d", t1);
    run_txn(32'h1000_0010, opcode_vload_c, 4'd7, '0, 1);

    // Unknown microop: accepted and dropped.
    run_txn(32'h1000_0000, OP_OTHER, 4'd4, '1, 0);

    // Random traffic over a small set of lines.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = opcode_vload_c;
        2, 3:    op = opcode_vstore_c;
        default: op = OP_OTHER;
      endcase
      for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
      run_txn(32'h4000_0000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31)),
              op, 4'($urandom_range(0, 15)), line, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
